ttag_event_reader: RTL and testbench

//   Timestamps trigger edges against the PPS-disciplined clock count and queues the tags for readout.

---
 rtl/ttag_pkg.sv | 33 +++
 rtl/ttag_fifo.sv | 106 ++++++++++
 rtl/ttag_event_reader.sv | 108 ++++++++++
 tb/tb_ttag_event_reader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ttag_pkg.sv
// Shared types and constants for the trigger timestamp reader.
// Optional build macro TTAG_INPUT_INVERT_EN is consumed by ttag_event_reader.
package ttag_pkg;

    localparam int CNT_W_DEF = 27;
    localparam int SEC_W_DEF = 32;
    localparam int DEPTH_DEF = 16;
    localparam int OVF_W_DEF = 16;
    localparam int TAG_W     = SEC_W_DEF + CNT_W_DEF;

    // Bit positions of the two monitored inputs inside the edge-detect vector.
    localparam int EV_PPS  = 0;
    localparam int EV_TRIG = 1;
    localparam int NUM_EV  = 2;

    typedef struct packed {
        logic [SEC_W_DEF-1:0] sec;
        logic [CNT_W_DEF-1:0] cnt;
    } ttag_t;

    // Encoding matches {push_en, pop_en} so the FIFO can cast it directly.
    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_POP  = 2'b01,
        FIFO_PUSH = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ttag_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is held in a
// register so dout is valid in the same cycle empty deasserts.
module ttag_fifo
    import ttag_pkg::*;
#(
    parameter  int DEPTH   = 16,
    parameter  int TAG_W   = 59,
    localparam int LEVEL_W = level_w(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic               clear,
    input  logic [TAG_W-1:0]   din,
    output logic [TAG_W-1:0]   dout,
    output logic               empty,
    output logic               full,
    output logic [LEVEL_W-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]        PTR_ONE = 1;
    localparam logic [AW-1:0]      ADR_ONE = 1;
    localparam logic [LEVEL_W-1:0] LVL_ONE = 1;
    localparam logic [LEVEL_W-1:0] LVL_MAX = DEPTH;

    logic [TAG_W-1:0]   mem [DEPTH];
    logic [AW:0]        wr_ptr_q, wr_ptr_d;
    logic [AW:0]        rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [TAG_W-1:0]   dout_q, dout_d;
    logic               push_en, pop_en;
    logic [AW-1:0]      rd_next_addr;
    fifo_op_e           op;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LVL_MAX);
    assign pop_en  = pop & ~empty & ~clear;
    // A push into a full FIFO is still accepted when a pop frees the slot.
    assign push_en = push & (~full | pop_en) & ~clear;
    assign op      = fifo_op_e'({push_en, pop_en});

    assign rd_next_addr = rd_ptr_q[AW-1:0] + ADR_ONE;

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        dout_d   = dout_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            case (op)
                FIFO_PUSH: begin
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    level_d  = level_q + LVL_ONE;
                    if (empty) begin
                        dout_d = din;
                    end
                end
                FIFO_POP: begin
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                    level_d  = level_q - LVL_ONE;
                    if (level_q != LVL_ONE) begin
                        dout_d = mem[rd_next_addr];
                    end
                end
                FIFO_BOTH: begin
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                    // With a single entry the incoming word becomes the new head.
                    dout_d   = (level_q == LVL_ONE) ? din : mem[rd_next_addr];
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            dout_q   <= dout_d;
        end
    end

    assign dout  = dout_q;
    assign level = level_q;

endmodule

// File: rtl/ttag_event_reader.sv
// Timestamps trigger edges against a PPS-cleared clock count and queues tags.
// Define TTAG_INPUT_INVERT_EN for active-low pps_in/trig_in sources.
module ttag_event_reader
    import ttag_pkg::*;
#(
    parameter  int CNT_W   = 27,
    parameter  int SEC_W   = 32,
    parameter  int DEPTH   = 16,
    parameter  int OVF_W   = 16,
    localparam int TW      = SEC_W + CNT_W,
    localparam int LEVEL_W = level_w(DEPTH)
) (
    input  logic               S_AXI_ACLK,
    input  logic               S_AXI_ARESETN,
    input  logic               pps_in,
    input  logic               trig_in,
    input  logic               clear,
    output logic [TW-1:0]      tag_data,
    output logic               tag_valid,
    input  logic               tag_ready,
    output logic [LEVEL_W-1:0] fifo_level,
    output logic [OVF_W-1:0]   overflow_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [SEC_W-1:0] SEC_ONE = 1;
    localparam logic [OVF_W-1:0] OVF_ONE = 1;

    logic [NUM_EV-1:0] in_raw, in_s, in_rise;
    logic [NUM_EV-1:0] hist_q;
    logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
    logic [SEC_W-1:0]  sec_cnt_q, sec_cnt_d;
    logic [OVF_W-1:0]  ovf_q, ovf_d;
    logic [TW-1:0]     tag_d;
    logic              pps_edge, trig_edge;
    logic              fifo_empty, fifo_full, pop, drop;

    assign in_raw[EV_PPS]  = pps_in;
    assign in_raw[EV_TRIG] = trig_in;

    // History registers live in the (possibly inverted) domain, so an input
    // that is already active at reset release never produces an edge.
    generate
        for (genvar gi = 0; gi < NUM_EV; gi++) begin : g_edge
`ifdef TTAG_INPUT_INVERT_EN
            assign in_s[gi] = ~in_raw[gi];
`else
            assign in_s[gi] = in_raw[gi];
`endif
            assign in_rise[gi] = in_s[gi] & ~hist_q[gi];
        end
    endgenerate

    assign pps_edge  = in_rise[EV_PPS];
    assign trig_edge = in_rise[EV_TRIG];

    assign clk_cnt_d = pps_edge ? '0 : clk_cnt_q + CNT_ONE;
    assign sec_cnt_d = pps_edge ? sec_cnt_q + SEC_ONE : sec_cnt_q;
    // A trigger coinciding with PPS belongs to the new second.
    assign tag_d     = pps_edge ? {sec_cnt_q + SEC_ONE, {CNT_W{1'b0}}}
                                : {sec_cnt_q, clk_cnt_q};

    assign pop  = ~fifo_empty & tag_ready;
    assign drop = trig_edge & fifo_full & ~pop & ~clear;

    always_comb begin
        ovf_d = ovf_q;
        if (clear) begin
            ovf_d = '0;
        end else if (drop && (ovf_q != '1)) begin
            ovf_d = ovf_q + OVF_ONE;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            hist_q    <= '1;
            clk_cnt_q <= '0;
            sec_cnt_q <= '0;
            ovf_q     <= '0;
        end else begin
            hist_q    <= in_s;
            clk_cnt_q <= clk_cnt_d;
            sec_cnt_q <= sec_cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    ttag_fifo #(
        .DEPTH (DEPTH),
        .TAG_W (TW)
    ) u_fifo (
        .clk   (S_AXI_ACLK),
        .rst_n (S_AXI_ARESETN),
        .push  (trig_edge),
        .pop   (pop),
        .clear (clear),
        .din   (tag_d),
        .dout  (tag_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (fifo_level)
    );

    assign tag_valid    = ~fifo_empty;
    assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_ttag_event_reader.sv
// Directed bench for ttag_event_reader using a small clock counter so that
// wrap-around and FIFO-full cases fit in a short run.
module tb_ttag_event_reader;

    localparam int CNT_W = 10;
    localparam int SEC_W = 32;
    localparam int DEPTH = 16;
    localparam int OVF_W = 2;
    localparam int TW    = SEC_W + CNT_W;
    localparam int LW    = $clog2(DEPTH) + 1;
`ifdef TTAG_INPUT_INVERT_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          pps_in    = 1'b1;
    logic          trig_in   = 1'b1;
    logic          clear     = 1'b0;
    logic          tag_ready = 1'b0;
    logic [TW-1:0] tag_data;
    logic          tag_valid;
    logic [LW-1:0] fifo_level;
    logic [OVF_W-1:0] overflow_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit pps, trig, rdy, clr;
        bit v;
        int lvl, ovf, sec, cnt;
    } vec_t;
    vec_t tbl[15];

    ttag_event_reader #(
        .CNT_W (CNT_W),
        .SEC_W (SEC_W),
        .DEPTH (DEPTH),
        .OVF_W (OVF_W)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .pps_in        (pps_in),
        .trig_in       (trig_in),
        .clear         (clear),
        .tag_data      (tag_data),
        .tag_valid     (tag_valid),
        .tag_ready     (tag_ready),
        .fifo_level    (fifo_level),
        .overflow_cnt  (overflow_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Levels are given in the active domain; inversion is applied here.
    task automatic drive(input bit p, input bit t, input bit r, input bit c);
        pps_in    = p ^ INV;
        trig_in   = t ^ INV;
        tag_ready = r;
        clear     = c;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_tag(input string name, input logic [SEC_W-1:0] sec, input logic [CNT_W-1:0] cnt);
        logic [TW-1:0] e;
        e = {sec, cnt};
        chk(name, tag_data, e);
    endtask

    task automatic do_reset;
        drive(0, 0, 0, 0);
        rst_n = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    initial begin
        // Test 1: both inputs high through reset release -> no tag.
        tick;
        tick;
        rst_n = 1'b1;
        repeat (3) tick;
        chk("t1_valid", tag_valid, 0);
        chk("t1_level", fifo_level, 0);
        chk("t1_data", tag_data, 0);
        chk("t1_ovf", overflow_cnt, 0);

        // Test 2: PPS held high for 100 cycles, then trigger -> {1,100}.
        drive(0, 0, 0, 0); tick;
        drive(1, 0, 0, 0); tick;
        repeat (100) tick;
        drive(1, 1, 0, 0); tick;
        chk("t2_valid", tag_valid, 1);
        chk("t2_level", fifo_level, 1);
        chk_tag("t2_data", 1, 100);
        drive(1, 1, 1, 0); tick;
        chk("t2_pop_valid", tag_valid, 0);
        chk("t2_pop_level", fifo_level, 0);

        // Test 3: advance to second 5, then coincident PPS + trigger -> {6,0}.
        drive(0, 0, 0, 0); tick;
        repeat (4) begin
            drive(1, 0, 0, 0); tick;
            drive(0, 0, 0, 0); tick;
        end
        drive(1, 1, 0, 0); tick;
        chk_tag("t3_data", 6, 0);
        chk("t3_level", fifo_level, 1);
        drive(0, 0, 1, 0); tick;
        chk("t3_pop_level", fifo_level, 0);

        // Multi-cycle trigger pulse yields exactly one tag.
        drive(0, 1, 0, 0); tick; tick; tick;
        drive(0, 0, 0, 0); tick; tick;
        chk("pulse_level", fifo_level, 1);
        chk_tag("pulse_data", 6, 1);
        drive(0, 0, 1, 0); tick;
        chk("pulse_pop_level", fifo_level, 0);

        // Cycle-by-cycle table starting from reset release (clk_cnt = 0).
        tbl[0]  = '{0, 0, 0, 0,  0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 0,  1, 1, 0, 0, 1};
        tbl[2]  = '{0, 1, 0, 0,  1, 1, 0, 0, 1};
        tbl[3]  = '{0, 0, 0, 0,  1, 1, 0, 0, 1};
        tbl[4]  = '{0, 1, 0, 0,  1, 2, 0, 0, 1};
        tbl[5]  = '{1, 0, 1, 0,  1, 1, 0, 0, 4};
        tbl[6]  = '{0, 1, 0, 0,  1, 2, 0, 0, 4};
        tbl[7]  = '{0, 0, 1, 0,  1, 1, 0, 1, 0};
        tbl[8]  = '{1, 1, 0, 0,  1, 2, 0, 1, 0};
        tbl[9]  = '{0, 0, 1, 0,  1, 1, 0, 2, 0};
        tbl[10] = '{0, 0, 1, 0,  0, 0, 0, 0, 0};
        tbl[11] = '{0, 0, 1, 0,  0, 0, 0, 0, 0};
        tbl[12] = '{0, 1, 0, 1,  0, 0, 0, 0, 0};
        tbl[13] = '{0, 0, 0, 0,  0, 0, 0, 0, 0};
        tbl[14] = '{0, 1, 0, 0,  1, 1, 0, 2, 5};
        do_reset;
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].pps, tbl[i].trig, tbl[i].rdy, tbl[i].clr);
            tick;
            chk($sformatf("tbl%0d_valid", i), tag_valid, tbl[i].v);
            chk($sformatf("tbl%0d_level", i), fifo_level, tbl[i].lvl);
            chk($sformatf("tbl%0d_ovf", i), overflow_cnt, tbl[i].ovf);
            if (tbl[i].v)
                chk_tag($sformatf("tbl%0d_data", i), tbl[i].sec[SEC_W-1:0], tbl[i].cnt[CNT_W-1:0]);
        end

        // Test 4: 17 triggers with no reader -> full, one drop, head is first tag.
        do_reset;
        repeat (17) begin
            drive(0, 0, 0, 0); tick;
            drive(0, 1, 0, 0); tick;
        end
        chk("t4_level", fifo_level, 16);
        chk("t4_ovf", overflow_cnt, 1);
        chk_tag("t4_head", 0, 1);
        drive(0, 0, 0, 0); tick;
        drive(0, 1, 1, 0); tick;
        chk("t4_pp_level", fifo_level, 16);
        chk("t4_pp_ovf", overflow_cnt, 1);
        chk_tag("t4_pp_head", 0, 3);
        repeat (3) begin
            drive(0, 0, 0, 0); tick;
            drive(0, 1, 0, 0); tick;
        end
        chk("t4_sat_ovf", overflow_cnt, 3);
        chk("t4_sat_level", fifo_level, 16);

        // Test 5: drain to 3 entries, then clear with a coincident trigger.
        drive(0, 0, 1, 0);
        repeat (13) tick;
        chk("t5_level3", fifo_level, 3);
        drive(0, 0, 0, 0); tick;
        drive(0, 1, 0, 1); tick;
        chk("t5_level", fifo_level, 0);
        chk("t5_ovf", overflow_cnt, 0);
        chk("t5_valid", tag_valid, 0);
        drive(0, 0, 0, 0); tick;
        chk("t5_after_level", fifo_level, 0);

        // Clock counter wraps modulo 2^CNT_W without PPS; seconds unchanged.
        do_reset;
        repeat (1025) tick;
        drive(0, 1, 0, 0); tick;
        chk("wrap_valid", tag_valid, 1);
        chk_tag("wrap_data", 0, 1);

        // Asynchronous reset takes effect before the next clock edge.
        rst_n = 1'b0;
        #2;
        chk("areset_valid", tag_valid, 0);
        chk("areset_level", fifo_level, 0);
        chk("areset_data", tag_data, 0);
        tick;
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
